// File: rtl/color_match_accum.sv
// Pixel-stream core of ColorDetect2: classifies RGB pixels against shadowed bounds and
// accumulates per-frame match count and coordinate sums, holding the result until acknowledged.
//
// state    | meaning
// IDLE     | disabled; pixels accepted and dropped
// WAIT_SOF | enabled; non-sof pixels dropped
// ACCUM    | accumulating the current frame
// DRAIN    | eof pixel passing through stage 2
// HOLD     | result presented, waiting for res_ack
module color_match_accum #(
    parameter int PIX_W = 8,
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int CNT_W = 20,
    parameter int SUM_W = 30
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               cfg_enable,
    input  logic [PIX_W-1:0]   cfg_r_min,
    input  logic [PIX_W-1:0]   cfg_r_max,
    input  logic [PIX_W-1:0]   cfg_g_min,
    input  logic [PIX_W-1:0]   cfg_g_max,
    input  logic [PIX_W-1:0]   cfg_b_min,
    input  logic [PIX_W-1:0]   cfg_b_max,
    input  logic [CNT_W-1:0]   cfg_min_count,
    input  logic               s_pix_valid,
    output logic               s_pix_ready,
    input  logic [3*PIX_W-1:0] s_pix_data,
    input  logic               s_pix_sof,
    input  logic               s_pix_eol,
    input  logic               s_pix_eof,
    output logic               res_valid,
    input  logic               res_ack,
    output logic [CNT_W-1:0]   res_count,
    output logic [SUM_W-1:0]   res_sum_x,
    output logic [SUM_W-1:0]   res_sum_y,
    output logic               res_detected,
    output logic               res_overflow,
    output logic               sync_err,
    output logic [15:0]        frame_cnt
);

    typedef enum logic [2:0] {IDLE, WAIT_SOF, ACCUM, DRAIN, HOLD} state_t;

    state_t             state_q, state_d;
    logic               ready_dec, xfer, take, abort, ack_fire;

    logic [6*PIX_W-1:0] sh_cfg_q, sh_cfg_d, cfg_vec, cfg_sel;
    logic [CNT_W-1:0]   sh_min_cnt_q, sh_min_cnt_d;
    logic [X_W-1:0]     x_q, x_d, pix_x;
    logic [Y_W-1:0]     y_q, y_d, pix_y;
    logic [PIX_W-1:0]   ch_r, ch_g, ch_b;
    logic               match;

    logic               s1_vld_q, s1_vld_d, s1_match_q, s1_match_d;
    logic               s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
    logic [X_W-1:0]     s1_x_q, s1_x_d;
    logic [Y_W-1:0]     s1_y_q, s1_y_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base, cnt_new;
    logic [SUM_W-1:0]   sx_q, sx_d, sx_base, sx_new;
    logic [SUM_W-1:0]   sy_q, sy_d, sy_base, sy_new;
    logic               ovf_q, ovf_d, ovf_new;
    logic [CNT_W:0]     cnt_sum;
    logic [SUM_W:0]     sx_sum, sy_sum;
    logic [X_W-1:0]     add_x;
    logic [Y_W-1:0]     add_y;

    logic               res_valid_q, res_valid_d, res_det_q, res_det_d, res_ovf_q, res_ovf_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic [SUM_W-1:0]   res_sx_q, res_sx_d, res_sy_q, res_sy_d;
    logic               sync_err_q, sync_err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    assign ready_dec   = (state_q == IDLE) || (state_q == WAIT_SOF) || (state_q == ACCUM);
    assign s_pix_ready = ready_dec && !ARESET;
    assign xfer        = s_pix_valid && s_pix_ready;

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        abort    = 1'b0;
        ack_fire = 1'b0;
        unique case (state_q)
            IDLE: if (cfg_enable) state_d = WAIT_SOF;
            WAIT_SOF: begin
                if (!cfg_enable) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (xfer && s_pix_sof) begin
                    take    = 1'b1;
                    state_d = s_pix_eof ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (!cfg_enable) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (xfer) begin
                    take = 1'b1;
                    if (s_pix_eof) state_d = DRAIN;
                end
            end
            DRAIN: state_d = HOLD;
            HOLD: begin
                if (res_valid_q && res_ack) begin
                    ack_fire = 1'b1;
                    state_d  = cfg_enable ? WAIT_SOF : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The sof pixel is classified with the live bounds, since the shadows load on that same edge.
    assign cfg_vec = {cfg_r_min, cfg_r_max, cfg_g_min, cfg_g_max, cfg_b_min, cfg_b_max};
    assign cfg_sel = s_pix_sof ? cfg_vec : sh_cfg_q;
    assign ch_r    = s_pix_data[3*PIX_W-1 -: PIX_W];
    assign ch_g    = s_pix_data[2*PIX_W-1 -: PIX_W];
    assign ch_b    = s_pix_data[PIX_W-1:0];
    assign match   = (ch_r >= cfg_sel[6*PIX_W-1 -: PIX_W]) && (ch_r <= cfg_sel[5*PIX_W-1 -: PIX_W]) &&
                     (ch_g >= cfg_sel[4*PIX_W-1 -: PIX_W]) && (ch_g <= cfg_sel[3*PIX_W-1 -: PIX_W]) &&
                     (ch_b >= cfg_sel[2*PIX_W-1 -: PIX_W]) && (ch_b <= cfg_sel[PIX_W-1:0]);
    assign pix_x   = s_pix_sof ? '0 : x_q;
    assign pix_y   = s_pix_sof ? '0 : y_q;

    always_comb begin
        sh_cfg_d     = sh_cfg_q;
        sh_min_cnt_d = sh_min_cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        s1_vld_d     = take;
        s1_match_d   = s1_match_q;
        s1_sof_d     = s1_sof_q;
        s1_eof_d     = s1_eof_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        sync_err_d   = take && (state_q == ACCUM) && s_pix_sof;
        if (take) begin
            s1_match_d = match;
            s1_sof_d   = s_pix_sof;
            s1_eof_d   = s_pix_eof;
            s1_x_d     = pix_x;
            s1_y_d     = pix_y;
            x_d        = s_pix_eol ? '0 : pix_x + X_W'(1);
            y_d        = s_pix_eol ? pix_y + Y_W'(1) : pix_y;
            if (s_pix_sof) begin
                sh_cfg_d     = cfg_vec;
                sh_min_cnt_d = cfg_min_count;
            end
        end
    end

    // Stage 2: saturating accumulate; a sof in stage 1 restarts from zero.
    assign cnt_base = s1_sof_q ? '0 : cnt_q;
    assign sx_base  = s1_sof_q ? '0 : sx_q;
    assign sy_base  = s1_sof_q ? '0 : sy_q;
    assign add_x    = s1_match_q ? s1_x_q : '0;
    assign add_y    = s1_match_q ? s1_y_q : '0;
    assign cnt_sum  = {1'b0, cnt_base} + {{CNT_W{1'b0}}, s1_match_q};
    assign sx_sum   = {1'b0, sx_base} + {{(SUM_W+1-X_W){1'b0}}, add_x};
    assign sy_sum   = {1'b0, sy_base} + {{(SUM_W+1-Y_W){1'b0}}, add_y};
    assign cnt_new  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    assign sx_new   = sx_sum[SUM_W] ? {SUM_W{1'b1}} : sx_sum[SUM_W-1:0];
    assign sy_new   = sy_sum[SUM_W] ? {SUM_W{1'b1}} : sy_sum[SUM_W-1:0];
    assign ovf_new  = (ovf_q && !s1_sof_q) || cnt_sum[CNT_W] || sx_sum[SUM_W] || sy_sum[SUM_W];

    always_comb begin
        cnt_d       = cnt_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        res_cnt_d   = res_cnt_q;
        res_sx_d    = res_sx_q;
        res_sy_d    = res_sy_q;
        res_det_d   = res_det_q;
        res_ovf_d   = res_ovf_q;
        frame_cnt_d = frame_cnt_q;
        if (abort || ack_fire) begin
            cnt_d = '0;
            sx_d  = '0;
            sy_d  = '0;
            ovf_d = 1'b0;
        end else if (s1_vld_q) begin
            cnt_d = cnt_new;
            sx_d  = sx_new;
            sy_d  = sy_new;
            ovf_d = ovf_new;
            if (s1_eof_q) begin
                res_valid_d = 1'b1;
                res_cnt_d   = cnt_new;
                res_sx_d    = sx_new;
                res_sy_d    = sy_new;
                res_det_d   = (cnt_new >= sh_min_cnt_q);
                res_ovf_d   = ovf_new;
            end
        end
        if (ack_fire) begin
            res_valid_d = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            sh_cfg_q     <= '0;
            sh_min_cnt_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            s1_vld_q     <= 1'b0;
            s1_match_q   <= 1'b0;
            s1_sof_q     <= 1'b0;
            s1_eof_q     <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            cnt_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            ovf_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_cnt_q    <= '0;
            res_sx_q     <= '0;
            res_sy_q     <= '0;
            res_det_q    <= 1'b0;
            res_ovf_q    <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sh_cfg_q     <= sh_cfg_d;
            sh_min_cnt_q <= sh_min_cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            s1_vld_q     <= s1_vld_d;
            s1_match_q   <= s1_match_d;
            s1_sof_q     <= s1_sof_d;
            s1_eof_q     <= s1_eof_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            cnt_q        <= cnt_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            ovf_q        <= ovf_d;
            res_valid_q  <= res_valid_d;
            res_cnt_q    <= res_cnt_d;
            res_sx_q     <= res_sx_d;
            res_sy_q     <= res_sy_d;
            res_det_q    <= res_det_d;
            res_ovf_q    <= res_ovf_d;
            sync_err_q   <= sync_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_count    = res_cnt_q;
    assign res_sum_x    = res_sx_q;
    assign res_sum_y    = res_sy_q;
    assign res_detected = res_det_q;
    assign res_overflow = res_ovf_q;
    assign sync_err     = sync_err_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
